// File: rtl/mem_arb_ctrl.sv
// Single-outstanding arbiter from imem/dmem requesters onto one single-port memory.
// Optional build macro MEM_ARB_RR_EN: alternate the grant when both sides contend.
module mem_arb_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq_val,
  output logic              ireq_rdy,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_val,
  output logic [DATA_W-1:0] iresp_data,
  input  logic              dreq_val,
  output logic              dreq_rdy,
  input  logic              dreq_type,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              dresp_val,
  output logic [DATA_W-1:0] dresp_rdata,
  output logic              memreq_val,
  output logic              memreq_type,
  output logic [ADDR_W-1:0] memreq_addr,
  output logic [DATA_W-1:0] memreq_wdata,
  input  logic              memresp_val,
  input  logic [DATA_W-1:0] memresp_rdata,
  output logic              err,
  output logic              dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             owner_d, owner_wr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             prio_d;
  logic             grant_d, grant_i, accept, done, timeout;

`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign prio_d = ~last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_d <= 1'b0;
    else if (accept) last_d <= grant_d;
  end
`else
  assign prio_d = 1'b1;
`endif

  assign cnt_inc = cnt + 1'b1;

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rst) begin
          grant_d = dreq_val & (~ireq_val | prio_d);
          grant_i = ireq_val & ~grant_d;
          if (grant_d | grant_i) state_nxt = WAIT;
        end
      end
      WAIT: begin
        done    = memresp_val;
        timeout = ~memresp_val & (cnt_inc == TIMEOUT_VAL);
        if (done | timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept       = grant_d | grant_i;
  assign ireq_rdy     = grant_i;
  assign dreq_rdy     = grant_d;
  assign memreq_val   = accept;
  assign memreq_type  = grant_d & dreq_type;
  assign memreq_addr  = grant_d ? dreq_addr : (grant_i ? ireq_addr : '0);
  assign memreq_wdata = grant_d ? dreq_wdata : '0;
  assign dbg_state    = (state == WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      owner_wr <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_d  <= grant_d;
        owner_wr <= grant_d & dreq_type;
        cnt      <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Responses are one-cycle pulses; data registers hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iresp_val   <= 1'b0;
      iresp_data  <= '0;
      dresp_val   <= 1'b0;
      dresp_rdata <= '0;
      err         <= 1'b0;
    end else begin
      iresp_val <= 1'b0;
      dresp_val <= 1'b0;
      if (done | timeout) begin
        if (owner_d) begin
          dresp_val   <= 1'b1;
          dresp_rdata <= (done & ~owner_wr) ? memresp_rdata : '0;
        end else begin
          iresp_val  <= 1'b1;
          iresp_data <= done ? memresp_rdata : '0;
        end
      end
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: directed scenarios plus random transactions against a
// transaction-level model of arbitration, response timing, timeout and data hold.
module tb_mem_arb_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ireq_val = 1'b0, ireq_rdy;
  logic [31:0] ireq_addr = '0;
  logic        iresp_val;
  logic [31:0] iresp_data;
  logic        dreq_val = 1'b0, dreq_rdy, dreq_type = 1'b0;
  logic [31:0] dreq_addr = '0, dreq_wdata = '0;
  logic        dresp_val;
  logic [31:0] dresp_rdata;
  logic        memreq_val, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic        memresp_val = 1'b0;
  logic [31:0] memresp_rdata = '0;
  logic        err, dbg_state;

  mem_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .ireq_val(ireq_val), .ireq_rdy(ireq_rdy), .ireq_addr(ireq_addr),
    .iresp_val(iresp_val), .iresp_data(iresp_data),
    .dreq_val(dreq_val), .dreq_rdy(dreq_rdy), .dreq_type(dreq_type),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dresp_val(dresp_val), .dresp_rdata(dresp_rdata),
    .memreq_val(memreq_val), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_rdata(memresp_rdata),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          exp_busy, last_d, own_d, own_wr, exp_err;
  bit          pend_i, pend_d;
  logic [31:0] pend_data, hold_i, hold_d;
  bit          dut_grant_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit d_wins_contest();
`ifdef MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called once per sampled cycle: response pulses, held data, err, busy state.
  task automatic check_common();
    chk("iresp_val", iresp_val, pend_i);
    chk("dresp_val", dresp_val, pend_d);
    if (pend_i) hold_i = pend_data;
    if (pend_d) hold_d = pend_data;
    chk("iresp_data", iresp_data, hold_i);
    chk("dresp_rdata", dresp_rdata, hold_d);
    chk("err", err, exp_err);
    chk("state", dbg_state, exp_busy);
    pend_i = 0;
    pend_d = 0;
  endtask

  task automatic reset_dut(input bit iv);
    ireq_val = iv;
    rst = 1'b0;
    exp_busy = 0; last_d = 0; exp_err = 0;
    pend_i = 0; pend_d = 0; hold_i = '0; hold_d = '0;
    @(negedge clk);
    check_common();
    chk("rst_ireq_rdy", ireq_rdy, 0);
    chk("rst_dreq_rdy", dreq_rdy, 0);
    chk("rst_memreq_val", memreq_val, 0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic issue(input bit iv, input logic [31:0] ia, input bit dv, input bit dt,
                       input logic [31:0] da, input logic [31:0] dw, input bit keep);
    bit gd;
    ireq_val = iv; ireq_addr = ia;
    dreq_val = dv; dreq_type = dt; dreq_addr = da; dreq_wdata = dw;
    @(negedge clk);
    gd = dv && (!iv || d_wins_contest());
    check_common();
    chk("ireq_rdy", ireq_rdy, iv && !gd);
    chk("dreq_rdy", dreq_rdy, gd);
    chk("memreq_val", memreq_val, 1);
    chk("memreq_type", memreq_type, gd && dt);
    chk("memreq_addr", memreq_addr, gd ? da : ia);
    if (gd) chk("memreq_wdata", memreq_wdata, dw);
    dut_grant_d = dreq_rdy;
    own_d = gd; own_wr = gd && dt; last_d = gd; exp_busy = 1;
    next_cycle();
    if (!keep) begin
      ireq_val = 0; dreq_val = 0;
      ireq_addr = $urandom; dreq_addr = $urandom; dreq_wdata = $urandom;
      dreq_type = 1'($urandom_range(0, 1));
    end
  endtask

  // k in 1..T: memory answers in WAIT cycle k; k == 0: memory never answers.
  task automatic respond(input int k, input logic [31:0] rd);
    int n;
    n = (k == 0) ? T : k;
    for (int j = 1; j <= n; j++) begin
      if (k != 0 && j == n) begin
        memresp_val = 1; memresp_rdata = rd;
      end
      @(negedge clk);
      check_common();
      chk("wait_ireq_rdy", ireq_rdy, 0);
      chk("wait_dreq_rdy", dreq_rdy, 0);
      chk("wait_memreq_val", memreq_val, 0);
      next_cycle();
      memresp_val = 0; memresp_rdata = $urandom;
    end
    exp_busy = 0;
    if (own_d) pend_d = 1; else pend_i = 1;
    pend_data = (k == 0 || own_wr) ? 32'h0 : rd;
    if (k == 0) exp_err = 1;
  endtask

  task automatic idle_cycle(input bit spurious);
    ireq_val = 0; dreq_val = 0;
    if (spurious) begin
      memresp_val = 1; memresp_rdata = $urandom;
    end
    @(negedge clk);
    check_common();
    chk("idle_ireq_rdy", ireq_rdy, 0);
    chk("idle_dreq_rdy", dreq_rdy, 0);
    chk("idle_memreq_val", memreq_val, 0);
    next_cycle();
    memresp_val = 0;
  endtask

  initial begin
    logic [3:0] gseq;
    int         kk;
    bit         iv, dv;

    next_cycle();
    // Reset with a fetch pending, then fetch 0x200 as soon as reset releases
    reset_dut(1);
    issue(1, 32'h200, 0, 0, 32'h0, 32'h0, 0);
    respond(1, 32'h00500093);
    idle_cycle(0);

    // Store, three-cycle memory latency, write ack carries data 0
    issue(0, 32'h0, 1, 1, 32'h2000, 32'h2A, 0);
    respond(3, 32'hDEADBEEF);
    idle_cycle(0);

    // Both requesters held valid for four back-to-back transactions
    reset_dut(0);
    gseq = '0;
    for (int t = 0; t < 4; t++) begin
      issue(1, 32'h100, 1, 0, 32'h3000, 32'h0, 1);
      gseq = {gseq[2:0], dut_grant_d};
      respond(1, $urandom);
    end
    idle_cycle(0);
`ifdef MEM_ARB_RR_EN
    chk("grant_seq", 32'(gseq), 32'hA);
`else
    chk("grant_seq", 32'(gseq), 32'hF);
`endif

    // Timeout, then late memory response ignored, err sticky
    issue(0, 32'h0, 1, 0, 32'h4000, 32'h0, 0);
    respond(0, 32'h0);
    idle_cycle(1);
    idle_cycle(0);
    issue(1, 32'h300, 0, 0, 32'h0, 32'h0, 0);
    respond(2, 32'h12345678);
    idle_cycle(0);

    // Reset while waiting, memory answers after release
    issue(1, 32'h400, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    check_common();
    next_cycle();
    reset_dut(0);
    idle_cycle(0);
    idle_cycle(1);
    idle_cycle(0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) dv = 1;
      kk = $urandom_range(1, T + 1);
      if (kk == T + 1) kk = 0;
      issue(iv, $urandom, dv, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
      respond(kk, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
